// File: rtl/fir_filter_param_pkg.sv
// Shared constants and width helpers for the parameterised FIR.
// Contents: MAX_TAPS, ADDR_W, DEFAULT_COEF (legacy 5-tap response),
// clog2() and acc_width().
package fir_pkg;

  localparam int unsigned MAX_TAPS = 8;

  // Reset coefficients; the first five reproduce the legacy fixed filter.
  localparam int unsigned DEFAULT_COEF [MAX_TAPS] = '{2, 3, 2, 5, 6, 0, 0, 0};

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Accumulator width that cannot overflow for TAPS full-scale products.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned taps);
    return data_w + coef_w + clog2(taps);
  endfunction

  localparam int unsigned ADDR_W = clog2(MAX_TAPS);

endpackage

// File: rtl/fir_filter_param_if.sv
// Sample / coefficient / result bundle of the parameterised FIR.
// master: sample source driving samples and coefficient writes.
// slave : the filter, driving out_valid / out_data / out_sat.
interface fir_filter_param_if
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned COEF_W = 4,
  parameter int unsigned OUT_W  = 12
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              coef_we;
  logic [ADDR_W-1:0] coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              out_sat;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_wdata,
    input  out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_wdata,
    output out_valid, out_data, out_sat
  );

endinterface

// File: rtl/fir_filter_param_coef_bank.sv
// TAPS x COEF_W coefficient register file.
// Ports: clk, rst (sync, active-high, loads DEFAULT_COEF), we/addr/wdata
// write port (addresses >= TAPS are ignored), coef_flat parallel read bus
// with tap k at bits [k*COEF_W +: COEF_W].
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int unsigned COEF_W = 4,
  parameter int unsigned TAPS   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [COEF_W-1:0]        wdata,
  output logic [TAPS*COEF_W-1:0]   coef_flat
);

  logic [COEF_W-1:0] coef_q [TAPS];

  // Only addresses matching an existing tap can hit, so out-of-range writes drop.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(TAPS); k++) begin
      if (rst) begin
        coef_q[k] <= COEF_W'(DEFAULT_COEF[k]);
      end else if (we && (32'(addr) == 32'(k))) begin
        coef_q[k] <= wdata;
      end
    end
  end

  always_comb begin
    coef_flat = '0;
    for (int k = 0; k < int'(TAPS); k++) begin
      coef_flat[k*COEF_W +: COEF_W] = coef_q[k];
    end
  end

endmodule

// File: rtl/fir_filter_param.sv
// Streaming unsigned direct-form FIR with runtime-writable coefficients.
// Ports: clk, rst (sync, active-high), bus (fir_filter_param_if.slave):
//   in_valid/in_data sample input, coef_we/coef_addr/coef_wdata coefficient
//   write, out_valid/out_data/out_sat registered result (1-cycle latency).
// Optional macro FIR_SAT_EN: when the accumulator is wider than OUT_W,
//   clip to 2^OUT_W-1 and flag out_sat; otherwise the result wraps.
module fir_filter_param
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned COEF_W = 4,
  parameter int unsigned TAPS   = 5,
  parameter int unsigned OUT_W  = 12
) (
  input  logic               clk,
  input  logic               rst,
  fir_filter_param_if.slave  bus
);

  localparam int unsigned ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int unsigned DLY_N = (TAPS > 1) ? TAPS - 1 : 1;

  logic [TAPS*COEF_W-1:0] coef_flat;
  logic [DATA_W-1:0]      dly [DLY_N];
  logic [ACC_W-1:0]       acc_c;
  logic [OUT_W-1:0]       res_c;
  logic                   sat_c;

  fir_coef_bank #(
    .COEF_W (COEF_W),
    .TAPS   (TAPS)
  ) u_coef_bank (
    .clk       (clk),
    .rst       (rst),
    .we        (bus.coef_we),
    .addr      (bus.coef_addr),
    .wdata     (bus.coef_wdata),
    .coef_flat (coef_flat)
  );

  // Delay line: dly[k] holds the sample accepted k+1 valid cycles ago.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(DLY_N); k++) dly[k] <= '0;
    end else if (bus.in_valid) begin
      dly[0] <= bus.in_data;
      for (int k = 1; k < int'(DLY_N); k++) dly[k] <= dly[k-1];
    end
  end

  // MAC over the live sample and the history; coefficients are pre-write values.
  always_comb begin
    acc_c = ACC_W'(bus.in_data) * ACC_W'(coef_flat[COEF_W-1:0]);
    for (int k = 1; k < int'(TAPS); k++) begin
      acc_c = acc_c + ACC_W'(dly[k-1]) * ACC_W'(coef_flat[k*COEF_W +: COEF_W]);
    end
  end

  // Fit the accumulator into OUT_W bits.
  if (ACC_W <= OUT_W) begin : g_extend
    always_comb begin
      res_c = OUT_W'(acc_c);
      sat_c = 1'b0;
    end
  end else begin : g_narrow
`ifdef FIR_SAT_EN
    always_comb begin
      res_c = acc_c[OUT_W-1:0];
      sat_c = 1'b0;
      if (acc_c[ACC_W-1:OUT_W] != '0) begin
        res_c = '1;
        sat_c = 1'b1;
      end
    end
`else
    always_comb begin
      res_c = acc_c[OUT_W-1:0];
      sat_c = 1'b0;
    end
`endif
  end

  // Output stage: updates only on accepted samples, holds through gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out_data <= res_c;
        bus.out_sat  <= sat_c;
      end
    end
  end

endmodule

// File: doc/fir_filter_param.md
Name: fir_filter_param

Overview:
Parameterised successor to the team's fixed 5-tap FIR. It is a streaming unsigned direct-form FIR with a runtime-writable coefficient bank, a valid-qualified sample path, one registered output stage and optional saturation. It sits between a sample source and downstream DSP logic. Reset defaults reproduce the legacy 5-tap response, coefficients {2,3,2,5,6}.

Parameters:
DATA_W, 4, input sample width (unsigned)
COEF_W, 4, coefficient width (unsigned)
TAPS, 5, number of taps, 1..MAX_TAPS (8)
OUT_W, 12, output width

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_data holds a new sample this cycle
in_data  input  DATA_W  sample x[n]
coef_we  input  1  coefficient write strobe
coef_addr  input  3  tap index to write
coef_wdata  input  COEF_W  coefficient value
out_valid  output  1  out_data updated this cycle
out_data  output  OUT_W  filter result
out_sat  output  1  out_data was clipped (FIR_SAT_EN only)

Behaviour:
- Reset (rst=1 at posedge) clears the following:
  - delay line d[1..TAPS-1] = 0
  - out_valid = 0, out_data = 0, out_sat = 0
  - coef[k] = DEFAULT_COEF[k] for k<TAPS
- Reset mid-stream discards all history. The first sample after reset sees zero history.
- Result: y = c0*x[n] + c1*d1 + ... + c(TAPS-1)*d(TAPS-1).
  - x[n] is taken combinationally from in_data.
  - d1 is the previous accepted sample, and so on down the line.
- Arithmetic:
  - all unsigned
  - product width DATA_W+COEF_W
  - accumulator width ACC_W = DATA_W+COEF_W+clog2(TAPS), so no internal overflow
- Latency is 1 cycle. When in_valid=1 at edge N:
  - d1 <= in_data and d(k) <= d(k-1)
  - out_data <= result; out_valid = 1 during cycle N+1
- in_valid=0: the delay line and out_data hold; out_valid = 0. Gaps do not alter results.
- Coefficient write: when coef_we=1 and coef_addr<TAPS, coef[coef_addr] <= coef_wdata at the edge.
  - Writes with coef_addr>=TAPS are ignored.
- Simultaneous coef_we and in_valid: the sample uses the OLD coefficient. The new value applies from the next sample.
- Output width: if ACC_W<=OUT_W, the result is zero-extended. Otherwise the behaviour is set by the optional feature.
- No backpressure: the block accepts one sample per cycle, every cycle.

Optional Feature:
FIR_SAT_EN
- Defined: a result above 2^OUT_W-1 gives out_data = 2^OUT_W-1 and out_sat=1. out_sat is registered alongside out_data and cleared on any unclipped result.
- Undefined: out_data = result mod 2^OUT_W (wrap-around), and out_sat is tied 0.

Decomposition:
- Package fir_pkg:
  - MAX_TAPS=8
  - DEFAULT_COEF[0:7] = {2,3,2,5,6,0,0,0}
  - function acc_width(DATA_W,COEF_W,TAPS)
  - clog2 helper
- Sub-module fir_coef_bank: the TAPS x COEF_W register file with write port, reset defaults and a flat parallel read bus.
- Delay line, MAC sum and output stage stay in the top module.

Test Plan:
- Default coefficients, reset, then in_valid=1 with x=5 followed by x=1 held -> out_data sequence 10,17,15,32,42,18,18,…, each one cycle after its sample.
- The same sequence with in_valid deasserted for 3 cycles between samples -> identical out_data values; out_valid pulses only after valid samples; out_data holds during gaps.
- After steady state at 18, write coef_addr=0 data=0 in the same cycle as a sample x=1 -> that output is 18; the next output is 16. A write to coef_addr=6 has no effect.
- OUT_W=8, all coefficients 15, x=15 held for 5 samples -> 5th output is 255 with out_sat=1 under FIR_SAT_EN, or 101 with out_sat=0 without it.
- Assert rst for one cycle mid-stream at steady state -> next cycle out_valid=0, out_data=0, coefficients back to defaults; the first following x=1 gives 2.
